// File: rtl/instr_fetch_decode.sv
// Fetch/decode front end of the K&S multicycle core: PC, IR, flags register and IR decode.
// Optional KS_ILLEGAL_TRAP_EN: illegal opcodes decode as I_HALT and set a sticky illegal_op flag.

package instr_fetch_decode_pkg;
  typedef enum logic [3:0] {
    I_NOP,
    I_BRANCH,
    I_BZERO,
    I_BNEG,
    I_BNZERO,
    I_BNNEG,
    I_LOAD,
    I_STORE,
    I_MOVE,
    I_ADD,
    I_SUB,
    I_AND,
    I_OR,
    I_HALT
  } decoded_instruction_type;
endpackage

module instr_fetch_decode
  import instr_fetch_decode_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ir_enable,
  input  logic                    pc_enable,
  input  logic                    branch,
  input  logic                    addr_sel,
  input  logic                    flags_reg_enable,
  input  logic                    alu_zero,
  input  logic                    alu_neg,
  input  logic                    alu_unsigned_ovf,
  input  logic                    alu_signed_ovf,
  input  logic [15:0]             ram_rdata,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output decoded_instruction_type decoded_instruction,
  output logic [1:0]              c_addr,
  output logic [1:0]              a_addr,
  output logic [1:0]              b_addr,
  output logic                    zero_op,
  output logic                    neg_op,
  output logic                    unsigned_overflow,
  output logic                    signed_overflow,
  output logic                    illegal_op
);

  // Control interface: there is no valid/ready handshake. Every strobe is a
  // one-cycle qualifier sampled on the rising edge; holding it repeats the action.

  logic [ADDR_WIDTH-1:0] pc;
  logic [15:0]           ir;
  logic [ADDR_WIDTH-1:0] ir_target;
  logic                  opcode_illegal;
  logic                  unused_ir_bit;

  assign ir_target     = ir[ADDR_WIDTH-1:0];
  assign unused_ir_bit = ir[7];

  // PC uses the IR held before this edge as branch target, even if IR loads now.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
    end else if (pc_enable) begin
      pc <= branch ? ir_target : pc + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir <= '0;
    end else if (ir_enable) begin
      ir <= ram_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_op           <= 1'b0;
      neg_op            <= 1'b0;
      unsigned_overflow <= 1'b0;
      signed_overflow   <= 1'b0;
    end else if (flags_reg_enable) begin
      zero_op           <= alu_zero;
      neg_op            <= alu_neg;
      unsigned_overflow <= alu_unsigned_ovf;
      signed_overflow   <= alu_signed_ovf;
    end
  end

  assign ram_addr = addr_sel ? pc : ir_target;

  always_comb begin
    decoded_instruction = I_NOP;
    c_addr              = 2'd0;
    a_addr              = 2'd0;
    b_addr              = 2'd0;
    opcode_illegal      = 1'b0;
    case (ir[15:8])
      8'h00: decoded_instruction = I_NOP;
      8'h01: decoded_instruction = I_BRANCH;
      8'h02: decoded_instruction = I_BZERO;
      8'h03: decoded_instruction = I_BNEG;
      8'h0A: decoded_instruction = I_BNZERO;
      8'h0B: decoded_instruction = I_BNNEG;
      8'h81: begin
        decoded_instruction = I_LOAD;
        c_addr              = ir[6:5];
      end
      8'h82: begin
        decoded_instruction = I_STORE;
        a_addr              = ir[6:5];
      end
      8'h91: begin
        decoded_instruction = I_MOVE;
        c_addr              = ir[3:2];
        a_addr              = ir[1:0];
      end
      8'hA1, 8'hA2, 8'hA3, 8'hA4: begin
        case (ir[9:8])
          2'd1:    decoded_instruction = I_ADD;
          2'd2:    decoded_instruction = I_SUB;
          2'd3:    decoded_instruction = I_AND;
          default: decoded_instruction = I_OR;
        endcase
        c_addr = ir[5:4];
        a_addr = ir[3:2];
        b_addr = ir[1:0];
      end
      8'hFF: decoded_instruction = I_HALT;
      default: begin
        opcode_illegal = 1'b1;
`ifdef KS_ILLEGAL_TRAP_EN
        decoded_instruction = I_HALT;
`else
        decoded_instruction = I_NOP;
`endif
      end
    endcase
  end

`ifdef KS_ILLEGAL_TRAP_EN
  // Sticky until reset; sets on the edge after an illegal word sits in the IR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_op <= 1'b0;
    end else if (opcode_illegal) begin
      illegal_op <= 1'b1;
    end
  end
`else
  logic unused_opcode_illegal;
  assign unused_opcode_illegal = opcode_illegal;
  assign illegal_op            = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Self-checking bench for instr_fetch_decode: decode vector table, hand sequences, random run vs model.
module tb_instr_fetch_decode;
  import instr_fetch_decode_pkg::*;

  localparam int AW = 5;

`ifdef KS_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    ir_enable, pc_enable, branch, addr_sel, flags_reg_enable;
  logic                    alu_zero, alu_neg, alu_unsigned_ovf, alu_signed_ovf;
  logic [15:0]             ram_rdata;
  logic [AW-1:0]           ram_addr;
  decoded_instruction_type decoded_instruction;
  logic [1:0]              c_addr, a_addr, b_addr;
  logic                    zero_op, neg_op, unsigned_overflow, signed_overflow, illegal_op;

  always #5 clk = ~clk;

  instr_fetch_decode #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .ir_enable(ir_enable), .pc_enable(pc_enable), .branch(branch), .addr_sel(addr_sel),
    .flags_reg_enable(flags_reg_enable),
    .alu_zero(alu_zero), .alu_neg(alu_neg),
    .alu_unsigned_ovf(alu_unsigned_ovf), .alu_signed_ovf(alu_signed_ovf),
    .ram_rdata(ram_rdata), .ram_addr(ram_addr),
    .decoded_instruction(decoded_instruction),
    .c_addr(c_addr), .a_addr(a_addr), .b_addr(b_addr),
    .zero_op(zero_op), .neg_op(neg_op),
    .unsigned_overflow(unsigned_overflow), .signed_overflow(signed_overflow),
    .illegal_op(illegal_op)
  );

  int errors = 0;
  int checks = 0;

  // Reference state: architectural registers only.
  int          pc_m;
  logic [15:0] ir_m;
  logic [3:0]  fl_m;   // {zero, neg, unsigned_ovf, signed_ovf}
  logic        ill_m;
  logic [15:0] mem [32];

  typedef struct {
    logic [15:0]             word;
    decoded_instruction_type dec;
    logic [1:0]              c, a, b;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit is_legal(input logic [7:0] op);
    logic [7:0] legal [14];
    legal = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h0A, 8'h0B, 8'h81, 8'h82, 8'h91,
              8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hFF};
    foreach (legal[i]) if (legal[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_decode(input logic [15:0] w, output decoded_instruction_type d,
                                       output logic [1:0] c, output logic [1:0] a,
                                       output logic [1:0] b);
    c = 2'd0; a = 2'd0; b = 2'd0;
    case (w[15:8])
      8'h00: d = I_NOP;
      8'h01: d = I_BRANCH;
      8'h02: d = I_BZERO;
      8'h03: d = I_BNEG;
      8'h0A: d = I_BNZERO;
      8'h0B: d = I_BNNEG;
      8'h81: begin d = I_LOAD;  c = w[6:5]; end
      8'h82: begin d = I_STORE; a = w[6:5]; end
      8'h91: begin d = I_MOVE;  c = w[3:2]; a = w[1:0]; end
      8'hA1: begin d = I_ADD; c = w[5:4]; a = w[3:2]; b = w[1:0]; end
      8'hA2: begin d = I_SUB; c = w[5:4]; a = w[3:2]; b = w[1:0]; end
      8'hA3: begin d = I_AND; c = w[5:4]; a = w[3:2]; b = w[1:0]; end
      8'hA4: begin d = I_OR;  c = w[5:4]; a = w[3:2]; b = w[1:0]; end
      8'hFF: d = I_HALT;
      default: d = TRAP ? I_HALT : I_NOP;
    endcase
  endfunction

  function automatic int model_addr(input logic asel);
    return asel ? pc_m : int'(ir_m) % 32;
  endfunction

  task automatic check_outputs(input logic asel);
    decoded_instruction_type d;
    logic [1:0] c, a, b;
    model_decode(ir_m, d, c, a, b);
    chk("ram_addr", 32'(ram_addr), 32'(model_addr(asel)));
    chk("decoded_instruction", 32'(decoded_instruction), 32'(d));
    chk("c_addr", 32'(c_addr), 32'(c));
    chk("a_addr", 32'(a_addr), 32'(a));
    chk("b_addr", 32'(b_addr), 32'(b));
    chk("flags", 32'({zero_op, neg_op, unsigned_overflow, signed_overflow}), 32'(fl_m));
    chk("illegal_op", 32'(illegal_op), 32'(ill_m));
  endtask

  // Drive one cycle's strobes, advance the model across the edge, compare #1 after it.
  task automatic cycle(input logic ie, input logic pe, input logic br, input logic asel,
                       input logic fe, input logic [3:0] af, input logic [15:0] rd);
    ir_enable = ie; pc_enable = pe; branch = br; addr_sel = asel; flags_reg_enable = fe;
    {alu_zero, alu_neg, alu_unsigned_ovf, alu_signed_ovf} = af;
    ram_rdata = rd;
    @(posedge clk);
    if (TRAP && !is_legal(ir_m[15:8])) ill_m = 1'b1;
    if (pe) pc_m = br ? int'(ir_m) % 32 : (pc_m + 1) % 32;
    if (ie) ir_m = rd;
    if (fe) fl_m = af;
    #1;
    check_outputs(asel);
  endtask

  task automatic model_reset();
    pc_m = 0; ir_m = 16'h0000; fl_m = 4'b0000; ill_m = 1'b0;
  endtask

  vec_t vecs [14];

  initial begin
    vecs = '{
      '{16'hA11B, I_ADD,    2'd1, 2'd2, 2'd3},
      '{16'h8147, I_LOAD,   2'd2, 2'd0, 2'd0},
      '{16'h8260, I_STORE,  2'd0, 2'd3, 2'd0},
      '{16'h910E, I_MOVE,   2'd3, 2'd2, 2'd0},
      '{16'hA2E4, I_SUB,    2'd2, 2'd1, 2'd0},
      '{16'hA33F, I_AND,    2'd3, 2'd3, 2'd3},
      '{16'hA416, I_OR,     2'd1, 2'd1, 2'd2},
      '{16'h0000, I_NOP,    2'd0, 2'd0, 2'd0},
      '{16'h0111, I_BRANCH, 2'd0, 2'd0, 2'd0},
      '{16'h0203, I_BZERO,  2'd0, 2'd0, 2'd0},
      '{16'h0304, I_BNEG,   2'd0, 2'd0, 2'd0},
      '{16'h0A05, I_BNZERO, 2'd0, 2'd0, 2'd0},
      '{16'h0B06, I_BNNEG,  2'd0, 2'd0, 2'd0},
      '{16'hFF00, I_HALT,   2'd0, 2'd0, 2'd0}
    };
    for (int i = 0; i < 32; i++) begin
      logic [7:0] ops [14];
      ops = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h0A, 8'h0B, 8'h81, 8'h82, 8'h91,
              8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hFF};
      mem[i] = {ops[$urandom_range(0, 13)], 8'($urandom_range(0, 255))};
    end
    mem[5] = 16'hA2E4;

    // Power-on reset
    rst = 1'b1;
    ir_enable = 0; pc_enable = 0; branch = 0; addr_sel = 1; flags_reg_enable = 0;
    {alu_zero, alu_neg, alu_unsigned_ovf, alu_signed_ovf} = 4'b0;
    ram_rdata = 16'h0;
    model_reset();
    #12;
    chk("reset ram_addr", 32'(ram_addr), 32'd0);
    chk("reset decode", 32'(decoded_instruction), 32'(I_NOP));
    chk("reset selects", 32'({c_addr, a_addr, b_addr}), 32'd0);
    chk("reset flags", 32'({zero_op, neg_op, unsigned_overflow, signed_overflow}), 32'd0);
    chk("reset illegal_op", 32'(illegal_op), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Decode table, IR loaded with addr_sel=0 so ram_addr shows the IR address field
    for (int i = 0; i < 14; i++) begin
      cycle(1, 0, 0, 0, 0, 4'b0, vecs[i].word);
      chk("tbl decode", 32'(decoded_instruction), 32'(vecs[i].dec));
      chk("tbl c_addr", 32'(c_addr), 32'(vecs[i].c));
      chk("tbl a_addr", 32'(a_addr), 32'(vecs[i].a));
      chk("tbl b_addr", 32'(b_addr), 32'(vecs[i].b));
      chk("tbl ram_addr", 32'(ram_addr), 32'(vecs[i].word % 16'd32));
    end

    // PC wrap, branch, branch without pc_enable
    cycle(1, 0, 0, 1, 0, 4'b0, 16'h011F);
    cycle(0, 1, 1, 1, 0, 4'b0, 16'h0);
    chk("pc branch to 31", 32'(ram_addr), 32'd31);
    cycle(0, 1, 0, 1, 0, 4'b0, 16'h0);
    chk("pc wrap", 32'(ram_addr), 32'd0);
    cycle(1, 0, 0, 1, 0, 4'b0, 16'h0113);
    cycle(0, 1, 1, 1, 0, 4'b0, 16'h0);
    chk("pc branch 0x13", 32'(ram_addr), 32'h13);
    cycle(0, 0, 1, 1, 0, 4'b0, 16'h0);
    chk("branch w/o pc_enable", 32'(ram_addr), 32'h13);

    // Flags capture then hold
    cycle(0, 0, 0, 1, 1, 4'b1000, 16'h0);
    chk("zero_op captured", 32'(zero_op), 32'd1);
    chk("neg_op captured", 32'(neg_op), 32'd0);
    cycle(0, 0, 0, 1, 0, 4'b0111, 16'h0);
    chk("zero_op hold", 32'(zero_op), 32'd1);
    chk("neg_op hold", 32'(neg_op), 32'd0);

    // Simultaneous ir_enable and pc_enable at PC=5
    cycle(1, 0, 0, 1, 0, 4'b0, 16'h0105);
    cycle(0, 1, 1, 1, 0, 4'b0, 16'h0);
    chk("pc at 5", 32'(ram_addr), 32'd5);
    cycle(1, 1, 0, 1, 0, 4'b0, mem[model_addr(1'b1)]);
    chk("pc after dual strobe", 32'(ram_addr), 32'd6);
    chk("ir word5 decode", 32'(decoded_instruction), 32'(I_SUB));
    chk("ir word5 c_addr", 32'(c_addr), 32'd2);
    cycle(0, 0, 0, 0, 0, 4'b0, 16'h0);
    chk("ir word5 addr field", 32'(ram_addr), 32'd4);

    // Illegal opcode
    cycle(1, 0, 0, 1, 0, 4'b0, 16'h5500);
    chk("illegal decode", 32'(decoded_instruction), 32'(TRAP ? I_HALT : I_NOP));
    chk("illegal_op not yet", 32'(illegal_op), 32'd0);
    cycle(1, 0, 0, 1, 0, 4'b0, 16'h0000);
    chk("illegal_op set", 32'(illegal_op), 32'(TRAP));
    cycle(0, 0, 0, 1, 0, 4'b0, 16'h0);
    chk("illegal_op sticky", 32'(illegal_op), 32'(TRAP));

    // Randomized run; RAM contents come from the model's address, not the DUT's
    for (int n = 0; n < 400; n++) begin
      logic ie, pe, br, asel, fe;
      logic [15:0] rd;
      ie = 1'($urandom_range(0, 1)); pe = 1'($urandom_range(0, 1));
      br = 1'($urandom_range(0, 1)); asel = 1'($urandom_range(0, 1));
      fe = 1'($urandom_range(0, 1));
      rd = ($urandom_range(0, 15) == 0) ? 16'($urandom) : mem[model_addr(asel)];
      cycle(ie, pe, br, asel, fe, 4'($urandom_range(0, 15)), rd);
    end

    // Mid-stream asynchronous reset with PC=0x0C, IR=0xA1xx, flags set
    cycle(1, 0, 0, 1, 0, 4'b0, 16'h010C);
    cycle(0, 1, 1, 1, 0, 4'b0, 16'h0);
    cycle(1, 0, 0, 1, 1, 4'b1111, 16'hA11B);
    chk("pre-reset pc", 32'(ram_addr), 32'h0C);
    chk("pre-reset decode", 32'(decoded_instruction), 32'(I_ADD));
    ir_enable = 0; flags_reg_enable = 0;
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    chk("async reset ram_addr", 32'(ram_addr), 32'd0);
    chk("async reset decode", 32'(decoded_instruction), 32'(I_NOP));
    chk("async reset selects", 32'({c_addr, a_addr, b_addr}), 32'd0);
    chk("async reset flags", 32'({zero_op, neg_op, unsigned_overflow, signed_overflow}), 32'd0);
    chk("async reset illegal_op", 32'(illegal_op), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cycle(0, 1, 0, 1, 0, 4'b0, 16'h0);
    chk("pc after reset release", 32'(ram_addr), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
